// File: rtl/stream_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_adder_pkg
// Purpose  : Shared lane result type and saturation-limit helpers for the
//            stream_adder datapath.
// Revision : 1.0 - initial multi-lane pipelined release
// ============================================================================
package stream_adder_pkg;

  // Widest lane the shared result type can carry; narrower lanes zero-fill.
  localparam int LANE_MAX_W = 64;

  // One lane's arithmetic outcome: value (low bits meaningful) and overflow.
  typedef struct packed {
    logic [LANE_MAX_W-1:0] result;
    logic                  ovf;
  } lane_res_t;

  // Largest representable value: all-ones unsigned, 0111..1 signed.
  function automatic logic [LANE_MAX_W-1:0] sat_max(input int width, input bit is_signed);
    logic [LANE_MAX_W-1:0] v;
    v = '0;
    for (int b = 0; b < LANE_MAX_W; b++) begin
      if ((b < width - 1) || ((b == width - 1) && !is_signed)) begin
        v[b] = 1'b1;
      end
    end
    return v;
  endfunction

  // Smallest representable value: zero unsigned, 1000..0 signed.
  function automatic logic [LANE_MAX_W-1:0] sat_min(input int width, input bit is_signed);
    logic [LANE_MAX_W-1:0] v;
    v = '0;
    for (int b = 0; b < LANE_MAX_W; b++) begin
      if (is_signed && (b == width - 1)) begin
        v[b] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_adder_if
// Purpose  : Valid/ready bundle carrying operand beats in and result beats
//            out of stream_adder. master = surrounding logic, slave = adder.
// Revision : 1.0 - initial multi-lane pipelined release
// ============================================================================
interface stream_adder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4
);

  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] addend1;
  logic [LANES*DATA_WIDTH-1:0] addend2;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] sum;
  logic [LANES-1:0]            overflow;

  modport master (
    output in_valid, addend1, addend2, out_ready,
    input  in_ready, out_valid, sum, overflow
  );

  modport slave (
    input  in_valid, addend1, addend2, out_ready,
    output in_ready, out_valid, sum, overflow
  );

endinterface
`default_nettype wire

// File: rtl/stream_adder_lane_add.sv
`default_nettype none
// ============================================================================
// Module   : lane_add
// Purpose  : Combinational single-lane add with overflow detection and
//            optional saturation.
// Revision : 1.0 - initial multi-lane pipelined release
// ============================================================================
module lane_add
  import stream_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit SIGNED     = 1'b1,
  parameter bit SATURATE   = 1'b0
) (
  input  wire logic [DATA_WIDTH-1:0] a,
  input  wire logic [DATA_WIDTH-1:0] b,
  output lane_res_t                  res
);

  localparam int                    c_msb = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] c_max = DATA_WIDTH'(sat_max(DATA_WIDTH, SIGNED));
  localparam logic [DATA_WIDTH-1:0] c_min = DATA_WIDTH'(sat_min(DATA_WIDTH, SIGNED));

  logic                  w_carry;
  logic [DATA_WIDTH-1:0] w_wrap;
  logic                  w_carry_into_msb;
  logic                  w_ovf;
  logic [DATA_WIDTH-1:0] w_sat;
  logic [DATA_WIDTH-1:0] w_val;

  assign {w_carry, w_wrap} = {1'b0, a} + {1'b0, b};

  // Signed overflow is carry-into-MSB differing from carry-out; this equals
  // "operands share a sign and the result sign differs".
  assign w_carry_into_msb = a[c_msb] ^ b[c_msb] ^ w_wrap[c_msb];
  assign w_ovf            = SIGNED ? (w_carry ^ w_carry_into_msb) : w_carry;

  // Signed overflow direction follows the common operand sign.
  assign w_sat = (SIGNED && a[c_msb]) ? c_min : c_max;
  assign w_val = (SATURATE && w_ovf) ? w_sat : w_wrap;

  assign res = {LANE_MAX_W'(w_val), w_ovf};

endmodule
`default_nettype wire

// File: rtl/stream_adder.sv
`default_nettype none
// ============================================================================
// Module   : stream_adder
// Purpose  : Multi-lane pipelined valid/ready adder with bubble-collapsing
//            stages, per-lane overflow and sticky overflow history.
// Revision : 1.0 - initial multi-lane pipelined release
// ============================================================================
module stream_adder
  import stream_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int STAGES     = 2,
  parameter bit SIGNED     = 1'b1,
  parameter bit SATURATE   = 1'b0
) (
  input  wire logic       clock,
  input  wire logic       reset,
  stream_adder_if.slave   bus,
  output logic [LANES-1:0] ovf_sticky,
  input  wire logic       ovf_clear
);

  localparam int c_bus_w = LANES * DATA_WIDTH;

  if (STAGES < 1) begin : g_bad_stages
    $error("stream_adder: STAGES must be at least 1");
  end
  if (DATA_WIDTH > LANE_MAX_W) begin : g_bad_width
    $error("stream_adder: DATA_WIDTH exceeds LANE_MAX_W");
  end

  lane_res_t [LANES-1:0]         w_res;
  logic [c_bus_w-1:0]            w_sum;
  logic [LANES-1:0]              w_ovf;
  logic [STAGES-1:0]             w_adv;
  logic                          w_out_xfer;
  logic [STAGES-1:0]             r_valid;
  logic [STAGES-1:0][c_bus_w-1:0] r_sum;
  logic [STAGES-1:0][LANES-1:0]  r_ovf;
  logic [LANES-1:0]              r_sticky;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_add #(
      .DATA_WIDTH (DATA_WIDTH),
      .SIGNED     (SIGNED),
      .SATURATE   (SATURATE)
    ) u_lane_add (
      .a   (bus.addend1[i*DATA_WIDTH +: DATA_WIDTH]),
      .b   (bus.addend2[i*DATA_WIDTH +: DATA_WIDTH]),
      .res (w_res[i])
    );

    assign w_sum[i*DATA_WIDTH +: DATA_WIDTH] = w_res[i].result[DATA_WIDTH-1:0];
    assign w_ovf[i]                          = w_res[i].ovf;

    // Bits above DATA_WIDTH are always zero-filled and carry no information.
    if (DATA_WIDTH < LANE_MAX_W) begin : g_pad
      logic w_pad_unused;
      assign w_pad_unused = ^w_res[i].result[LANE_MAX_W-1:DATA_WIDTH];
    end
  end

  // A stage moves when it is empty or its successor moves; the sink is out_ready.
  always_comb begin
    logic w_chain;
    w_chain = bus.out_ready;
    w_adv   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_chain  = !r_valid[k] || w_chain;
      w_adv[k] = w_chain;
    end
  end

  // Combinational out_ready -> in_ready path; held low throughout reset.
  assign bus.in_ready = w_adv[0] & ~reset;

  // Stage 0 captures lane results on acceptance; later stages are pure delay.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_sum   <= '0;
      r_ovf   <= '0;
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= bus.in_valid;
        if (bus.in_valid) begin
          r_sum[0] <= w_sum;
          r_ovf[0] <= w_ovf;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_sum[k] <= r_sum[k-1];
            r_ovf[k] <= r_ovf[k-1];
          end
        end
      end
    end
  end

  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.sum       = r_sum[STAGES-1];
  assign bus.overflow  = r_ovf[STAGES-1];
  assign w_out_xfer    = r_valid[STAGES-1] & bus.out_ready;

  // Sticky history: a delivered overflow sets its bit and beats a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= ({LANES{~ovf_clear}} & r_sticky) |
                  ({LANES{w_out_xfer}} & r_ovf[STAGES-1]);
    end
  end

  assign ovf_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_stream_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_adder
// Purpose  : Directed bench for stream_adder: an unsigned/wrap and a
//            signed/saturate instance share one stimulus stream.
// Revision : 1.0 - initial multi-lane pipelined release
// ============================================================================
module tb_stream_adder;

  typedef struct {
    logic [15:0] a1;
    logic [15:0] a2;
    logic [15:0] u_sum;
    logic [1:0]  u_ovf;
    logic [15:0] s_sum;
    logic [1:0]  s_ovf;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] addend1;
  logic [15:0] addend2;
  logic        out_ready;
  logic        ovf_clear;
  logic [1:0]  ovf_sticky_u;
  logic [1:0]  ovf_sticky_s;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs [6];

  stream_adder_if #(.DATA_WIDTH(8), .LANES(2)) bus_u ();
  stream_adder_if #(.DATA_WIDTH(8), .LANES(2)) bus_s ();

  assign bus_u.in_valid  = in_valid;
  assign bus_u.addend1   = addend1;
  assign bus_u.addend2   = addend2;
  assign bus_u.out_ready = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.addend1   = addend1;
  assign bus_s.addend2   = addend2;
  assign bus_s.out_ready = out_ready;

  stream_adder #(
    .DATA_WIDTH(8), .LANES(2), .STAGES(2), .SIGNED(1'b0), .SATURATE(1'b0)
  ) dut_u (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_u),
    .ovf_sticky (ovf_sticky_u),
    .ovf_clear  (ovf_clear)
  );

  stream_adder #(
    .DATA_WIDTH(8), .LANES(2), .STAGES(2), .SIGNED(1'b1), .SATURATE(1'b1)
  ) dut_s (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_s),
    .ovf_sticky (ovf_sticky_s),
    .ovf_clear  (ovf_clear)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a1, input logic [15:0] a2);
    in_valid = v;
    addend1  = a1;
    addend2  = a2;
  endtask

  function automatic logic [15:0] bp_a1(input int j);
    return {8'(j + 16), 8'(j)};
  endfunction

  function automatic logic [15:0] bp_exp(input int j);
    return {8'(j + 17), 8'(j + 1)};
  endfunction

  initial begin
    int   accepted;
    int   j;
    int   k;
    int   first;
    int   nres;
    logic found;

    // {addend1, addend2, unsigned-wrap sum/ovf, signed-saturate sum/ovf}; lane1 in the high byte
    vecs[0] = '{16'h01F0, 16'h0220, 16'h0310, 2'b01, 16'h0310, 2'b00};
    vecs[1] = '{16'h807F, 16'hFF01, 16'h7F80, 2'b10, 16'h807F, 2'b11};
    vecs[2] = '{16'h0005, 16'h00FB, 16'h0000, 2'b01, 16'h0000, 2'b00};
    vecs[3] = '{16'h80FF, 16'h80FF, 16'h00FE, 2'b11, 16'h80FE, 2'b10};
    vecs[4] = '{16'h7F40, 16'h8040, 16'hFF80, 2'b00, 16'hFF7F, 2'b01};
    vecs[5] = '{16'hC012, 16'hC034, 16'h8046, 2'b10, 16'h8046, 2'b00};

    reset     = 1'b1;
    out_ready = 1'b1;
    ovf_clear = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);

    // Reset state
    repeat (2) tick();
    check("rst_out_valid", bus_u.out_valid, 0);
    check("rst_sum", bus_u.sum, 0);
    check("rst_overflow", bus_u.overflow, 0);
    check("rst_sticky", ovf_sticky_u, 0);
    check("rst_in_ready", bus_u.in_ready, 0);
    check("rst_in_ready_s", bus_s.in_ready, 0);
    reset = 1'b0;
    tick();

    // Table: one beat per cycle, result expected two cycles after drive
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(1'b1, vecs[i].a1, vecs[i].a2);
      else       drive(1'b0, 16'h0000, 16'h0000);
      #1;
      if (i < 6) check("tbl_in_ready", bus_u.in_ready, 1);
      if (i < 2) begin
        check("tbl_lat_u", bus_u.out_valid, 0);
        check("tbl_lat_s", bus_s.out_valid, 0);
      end else begin
        check("tbl_valid_u", bus_u.out_valid, 1);
        check("tbl_sum_u", bus_u.sum, vecs[i-2].u_sum);
        check("tbl_ovf_u", bus_u.overflow, vecs[i-2].u_ovf);
        check("tbl_valid_s", bus_s.out_valid, 1);
        check("tbl_sum_s", bus_s.sum, vecs[i-2].s_sum);
        check("tbl_ovf_s", bus_s.overflow, vecs[i-2].s_ovf);
      end
      tick();
    end
    check("tbl_sticky_u", ovf_sticky_u, 2'b11);
    check("tbl_sticky_s", ovf_sticky_s, 2'b11);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("clr_sticky_u", ovf_sticky_u, 2'b00);
    check("clr_sticky_s", ovf_sticky_s, 2'b00);

    // Sticky: lane1-only overflow sets 2'b10 and holds
    drive(1'b1, 16'h8001, 16'h8001);
    tick();
    drive(1'b0, 16'h0000, 16'h0000);
    repeat (3) tick();
    check("stk_set_u", ovf_sticky_u, 2'b10);
    check("stk_set_s", ovf_sticky_s, 2'b10);
    repeat (2) tick();
    check("stk_hold_u", ovf_sticky_u, 2'b10);

    // Clear coinciding with another lane1-overflow transfer: set wins
    drive(1'b1, 16'h8001, 16'h8001);
    tick();
    drive(1'b0, 16'h0000, 16'h0000);
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      if (bus_u.out_valid) found = 1'b1;
      else tick();
    end
    check("stk_wait", found, 1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("stk_race_u", ovf_sticky_u, 2'b10);
    check("stk_race_s", ovf_sticky_s, 2'b10);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("stk_clear_u", ovf_sticky_u, 2'b00);

    // Backpressure: output stalled for 6 cycles while offering beats 1..5
    out_ready = 1'b0;
    accepted  = 0;
    j         = 1;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, bp_a1(j), 16'h0101);
      #1;
      if (bus_u.out_valid) check("bp_hold_sum", bus_u.sum, bp_exp(1));
      if (bus_u.in_ready) begin
        accepted++;
        j++;
      end
      tick();
    end
    check("bp_accepted", accepted, 2);
    check("bp_in_ready_u", bus_u.in_ready, 0);
    check("bp_in_ready_s", bus_s.in_ready, 0);
    check("bp_stall_valid", bus_u.out_valid, 1);
    check("bp_stall_sum", bus_u.sum, bp_exp(1));

    out_ready = 1'b1;
    k = 1;
    for (int c = 0; c < 30 && k <= 5; c++) begin
      drive(j <= 5, bp_a1(j), 16'h0101);
      #1;
      if (bus_u.out_valid) begin
        check("bp_order_u", bus_u.sum, bp_exp(k));
        check("bp_order_s", bus_s.sum, bp_exp(k));
        k++;
      end
      if (in_valid && bus_u.in_ready) j++;
      tick();
    end
    drive(1'b0, 16'h0000, 16'h0000);
    check("bp_count", k, 6);

    // Throughput: 16 back-to-back beats with the sink always ready
    first = -1;
    nres  = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive(1'b1, {8'(i), 8'(i)}, 16'h0102);
      else        drive(1'b0, 16'h0000, 16'h0000);
      #1;
      if (i < 16) check("tp_in_ready", bus_u.in_ready, 1);
      if (bus_u.out_valid) begin
        if (first < 0) first = i;
        check("tp_sum_u", bus_u.sum, {8'(nres + 1), 8'(nres + 2)});
        check("tp_sum_s", bus_s.sum, {8'(nres + 1), 8'(nres + 2)});
        nres++;
      end
      tick();
    end
    check("tp_first", first, 2);
    check("tp_count", nres, 16);

    // Reset mid-stream with two beats in flight and lane0 sticky set
    drive(1'b1, 16'h01F0, 16'h0220);
    tick();
    drive(1'b0, 16'h0000, 16'h0000);
    repeat (3) tick();
    check("mr_pre_sticky_u", ovf_sticky_u, 2'b01);
    check("mr_pre_sticky_s", ovf_sticky_s, 2'b00);
    out_ready = 1'b0;
    drive(1'b1, bp_a1(1), 16'h0101);
    tick();
    drive(1'b1, bp_a1(2), 16'h0101);
    tick();
    drive(1'b0, 16'h0000, 16'h0000);
    check("mr_pre_valid", bus_u.out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_out_valid", bus_u.out_valid, 0);
    check("mr_sum", bus_u.sum, 0);
    check("mr_overflow", bus_u.overflow, 0);
    check("mr_sticky", ovf_sticky_u, 0);
    check("mr_in_ready", bus_u.in_ready, 0);
    out_ready = 1'b1;
    @(posedge clock);
    #3;
    reset = 1'b0;
    repeat (5) begin
      tick();
      check("mr_quiet", bus_u.out_valid, 0);
    end
    drive(1'b1, bp_a1(7), 16'h0101);
    tick();
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    check("mr_new_valid", bus_u.out_valid, 1);
    check("mr_new_sum", bus_u.sum, bp_exp(7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
